// File: rtl/watch_set_core.sv
// ============================================================================
// Module   : watch_set_core
// Purpose  : HH:MM:SS watch with free-running seconds and a RUN/SET edit mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_set_core #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int HOURS_MAX     = 24,
   parameter int BLINK_DIV     = TICKS_PER_SEC / 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_mode,
   input  logic        btn_sel,
   input  logic        btn_inc,
   input  logic        btn_dec,
   output logic [23:0] time_bcd,
   output logic        set_mode,
   output logic [1:0]  sel_field,
   output logic        blink_phase,
   output logic        sec_tick
);

   localparam int              c_PW         = $clog2(TICKS_PER_SEC);
   localparam int              c_BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICKS_PER_SEC - 1);
   localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);
   localparam logic [4:0]      c_HOUR_LAST  = 5'(HOURS_MAX - 1);

   localparam logic [0:0] c_RUN = 1'b0;
   localparam logic [0:0] c_SET = 1'b1;

   logic [0:0]      r_state;
   logic [c_PW-1:0] r_presc;
   logic [c_BW-1:0] r_blink_cnt;
   logic            r_blink_phase;
   logic            r_sec_tick;
   logic [1:0]      r_sel;
   logic [5:0]      r_live_s, r_live_m, r_shd_s, r_shd_m;
   logic [4:0]      r_live_h, r_shd_h;
   logic [23:0]     r_time_bcd;

   logic [0:0]      w_state_nx;
   logic [c_PW-1:0] w_presc_nx;
   logic [1:0]      w_sel_nx;
   logic [5:0]      w_live_s_nx, w_live_m_nx, w_shd_s_nx, w_shd_m_nx;
   logic [4:0]      w_live_h_nx, w_shd_h_nx;
   logic [5:0]      w_disp_s, w_disp_m;
   logic [4:0]      w_disp_h;
   logic            w_enter, w_exit, w_edit;

   function automatic logic [5:0] inc59(input logic [5:0] v);
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] dec59(input logic [5:0] v);
      return (v == 6'd0) ? 6'd59 : v - 6'd1;
   endfunction

   function automatic logic [7:0] bcd2(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

   assign w_enter = (r_state == c_RUN) && btn_mode;
   assign w_exit  = (r_state == c_SET) && btn_mode;
   assign w_edit  = (r_state == c_SET) && !btn_mode;

   assign w_state_nx = btn_mode ? ~r_state : r_state;
   assign w_presc_nx = (w_exit || r_presc == c_PRESC_LAST) ? '0 : r_presc + 1'b1;

   // The SET-exit load takes precedence over a coinciding second advance.
   always_comb begin
      w_live_s_nx = r_live_s;
      w_live_m_nx = r_live_m;
      w_live_h_nx = r_live_h;
      if (w_exit) begin
         w_live_s_nx = r_shd_s;
         w_live_m_nx = r_shd_m;
         w_live_h_nx = r_shd_h;
      end else if (r_sec_tick) begin
         w_live_s_nx = inc59(r_live_s);
         if (r_live_s == 6'd59) begin
            w_live_m_nx = inc59(r_live_m);
            if (r_live_m == 6'd59)
               w_live_h_nx = (r_live_h == c_HOUR_LAST) ? 5'd0 : r_live_h + 5'd1;
         end
      end
   end

   always_comb begin
      w_shd_s_nx = r_shd_s;
      w_shd_m_nx = r_shd_m;
      w_shd_h_nx = r_shd_h;
      w_sel_nx   = r_sel;
      if (w_enter) begin
         w_shd_s_nx = w_live_s_nx;
         w_shd_m_nx = w_live_m_nx;
         w_shd_h_nx = w_live_h_nx;
         w_sel_nx   = 2'd0;
      end else if (w_edit) begin
         if (btn_sel)
            w_sel_nx = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
         if (btn_inc ^ btn_dec) begin
            case (r_sel)
               2'd0:    w_shd_s_nx = btn_inc ? inc59(r_shd_s) : dec59(r_shd_s);
               2'd1:    w_shd_m_nx = btn_inc ? inc59(r_shd_m) : dec59(r_shd_m);
               2'd2: begin
                  if (btn_inc)
                     w_shd_h_nx = (r_shd_h == c_HOUR_LAST) ? 5'd0 : r_shd_h + 5'd1;
                  else
                     w_shd_h_nx = (r_shd_h == 5'd0) ? c_HOUR_LAST : r_shd_h - 5'd1;
               end
               default: ;
            endcase
         end
      end
   end

   // Display is registered from next-state values so it tracks state without lag.
   assign w_disp_s = (w_state_nx == c_SET) ? w_shd_s_nx : w_live_s_nx;
   assign w_disp_m = (w_state_nx == c_SET) ? w_shd_m_nx : w_live_m_nx;
   assign w_disp_h = (w_state_nx == c_SET) ? w_shd_h_nx : w_live_h_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= c_RUN;
         r_presc       <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_sec_tick    <= 1'b0;
         r_sel         <= 2'd0;
         r_live_s      <= 6'd0;
         r_live_m      <= 6'd0;
         r_live_h      <= 5'd0;
         r_shd_s       <= 6'd0;
         r_shd_m       <= 6'd0;
         r_shd_h       <= 5'd0;
         r_time_bcd    <= 24'd0;
      end else begin
         r_state    <= w_state_nx;
         r_presc    <= w_presc_nx;
         r_sec_tick <= (w_presc_nx == c_PRESC_LAST);
         if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
         r_sel      <= w_sel_nx;
         r_live_s   <= w_live_s_nx;
         r_live_m   <= w_live_m_nx;
         r_live_h   <= w_live_h_nx;
         r_shd_s    <= w_shd_s_nx;
         r_shd_m    <= w_shd_m_nx;
         r_shd_h    <= w_shd_h_nx;
         r_time_bcd <= {bcd2({1'b0, w_disp_h}), bcd2(w_disp_m), bcd2(w_disp_s)};
      end
   end

   assign time_bcd    = r_time_bcd;
   assign set_mode    = (r_state == c_SET);
   assign sel_field   = r_sel;
   assign blink_phase = r_blink_phase;
   assign sec_tick    = r_sec_tick;

endmodule

`default_nettype wire

// File: doc/watch_set_core.md
WATCH_SET_CORE -- requirements
Module: watch_set_core

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000: clk cycles per second; legal range 2..2^27.
REQ-002 SHALL have parameter HOURS_MAX, default 24: hour count modulus; legal range 2..24; hours run 0..HOURS_MAX-1.
REQ-003 SHALL have parameter BLINK_DIV, default TICKS_PER_SEC/2: clk cycles per blink_phase toggle; minimum 1.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port btn_mode, input, 1: single-cycle pulse from an external debouncer; toggles RUN/SET.
REQ-007 SHALL have port btn_sel, input, 1: pulse; advances the edit field in SET.
REQ-008 SHALL have port btn_inc, input, 1: pulse; increments the selected field in SET.
REQ-009 SHALL have port btn_dec, input, 1: pulse; decrements the selected field in SET.
REQ-010 SHALL have port time_bcd, output, 24: {hour10,hour1,min10,min1,sec10,sec1}, 4-bit BCD each; shows the shadow time in SET and the live time in RUN.
REQ-011 SHALL have port set_mode, output, 1: high while in SET.
REQ-012 SHALL have port sel_field, output, 2: edit field; 0=sec, 1=min, 2=hour.
REQ-013 SHALL have port blink_phase, output, 1: toggles every BLINK_DIV cycles, free-running.
REQ-014 SHALL have port sec_tick, output, 1: one-cycle pulse when the live time advances.

Function
REQ-015 SHALL keep a prescaler of width clog2(TICKS_PER_SEC); it counts 0..TICKS_PER_SEC-1 and wraps to 0.
REQ-016 SHALL assert sec_tick for exactly the cycle in which the prescaler wraps, in both RUN and SET.
REQ-017 SHALL advance the live time by one second on the clock edge following sec_tick assertion, i.e. time_bcd changes 1 cycle after sec_tick.
REQ-018 SHALL carry as sec 59->00 with min+1, min 59->00 with hour+1, and hour HOURS_MAX-1 -> 00.
REQ-019 SHALL implement a two-state machine, RUN and SET, with reset state RUN.
REQ-020 SHALL, in RUN on btn_mode, enter SET, copy the live time into the shadow registers in the same edge, and set sel_field=0.
REQ-021 SHALL keep the live time running during SET.
REQ-022 SHALL, in SET on btn_mode, return to RUN, load the shadow time into the live time, and clear the prescaler to 0 in the same edge.
REQ-023 SHALL, in SET, advance sel_field on btn_sel as 0->1->2->0; btn_sel SHALL be ignored in RUN.
REQ-024 SHALL, in SET, wrap the selected shadow field without carry: sec and min inc 59->00 and dec 00->59; hour inc HOURS_MAX-1->00 and dec 00->HOURS_MAX-1.
REQ-025 SHALL make no shadow change when btn_inc and btn_dec are asserted in the same cycle.
REQ-026 SHALL ignore btn_inc and btn_dec in RUN.
REQ-027 SHALL give btn_mode priority over btn_sel, btn_inc and btn_dec in the same cycle; the others are discarded.
REQ-028 SHALL let the SET-exit load win when it coincides with a live-time advance; the loaded value is exact and the prescaler restarts at 0.
REQ-029 SHALL hold all BCD digits valid (0..9, with tens limits 5 for min/sec and per HOURS_MAX for hours) at every cycle.
REQ-030 SHALL make time_bcd, set_mode, sel_field, blink_phase and sec_tick registered outputs with no combinational path from the btn_* inputs.

Reset
REQ-031 SHALL, on reset_n low, immediately clear the live time, shadow, prescaler, blink counter, blink_phase, sel_field, set_mode and sec_tick to 0 and force RUN.
REQ-032 SHALL resume counting on the first rising clk edge after reset_n deasserts; reset asserted during SET discards the shadow.

Verification (TICKS_PER_SEC=10, HOURS_MAX=24, BLINK_DIV=5)
REQ-033 SHALL pass: release reset, run 100 cycles -> 10 sec_tick pulses, time_bcd=24'h000010.
REQ-034 SHALL pass: load live time 23:59:59 via SET, exit, wait 10 cycles -> time_bcd=24'h000000 one cycle after sec_tick.
REQ-035 SHALL pass: SET, sel_field=2, btn_dec at hour 00 -> hour 23; sel_field=0, btn_inc at 59 -> 00 with min unchanged.
REQ-036 SHALL pass: SET with btn_inc and btn_dec in the same cycle -> shadow unchanged; btn_mode plus btn_inc in the same cycle -> exit to RUN, no increment.
REQ-037 SHALL pass: SET exit coinciding with sec_tick, shadow 12:34:56 -> live 12:34:56, next sec_tick 10 cycles later.
REQ-038 SHALL pass: reset_n pulsed low mid-cycle while in SET -> outputs 0 asynchronously, set_mode=0 before the next clk edge.
